// File: rtl/sha_pll_reset_seq.sv
// rtl/sha_pll_reset_seq.sv - SHA PLL lock supervisor and staggered core reset/enable sequencer
// Optional lock-loss event counter built only when SHA_PLL_LOCK_LOSS_CNT_EN is defined.
module sha_pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int NUM_CORES     = 10,
    parameter int STAGGER       = 4,
    parameter int CNT_W         = 16
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 retry_req,
    output logic                 pll_rst,
    output logic                 core_rst_n,
    output logic [NUM_CORES-1:0] core_en,
    output logic                 ready,
    output logic                 fail,
    output logic [2:0]           state_o,
    output logic [7:0]           lock_loss_cnt
);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic                 lock_meta;
    logic                 locked_s;
    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [RETRY_W-1:0]   retry_nx;
    logic [NUM_CORES-1:0] en_nx;

    // Single cycle counter is reused by every state: reset pulse, lock timeout,
    // stability window and, in RUN, the spacing between core enables.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        retry_nx = retry_cnt;
        en_nx    = '0;
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = S_STABLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nx = '0;
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nx = S_FAIL;
                    end else begin
                        retry_nx = retry_cnt + RETRY_W'(1);
                        state_nx = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                // A dropout here is treated as a glitch, not a failed attempt.
                if (!locked_s) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    retry_nx = '0;
                    en_nx    = NUM_CORES'(1);
                end
            end
            S_RUN: begin
                // Lock loss wins over any stagger step due this cycle.
                if (!locked_s) begin
                    state_nx = S_PLL_RST;
                    cnt_nx   = '0;
                end else begin
                    en_nx = core_en;
                    if (cnt == STAGGER_LAST) begin
                        cnt_nx = '0;
                        en_nx  = core_en | (core_en << 1);
                    end
                end
            end
            S_FAIL: begin
                cnt_nx = '0;
                if (retry_req) begin
                    state_nx = S_PLL_RST;
                    retry_nx = '0;
                end
            end
            default: begin
                state_nx = S_PLL_RST;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_meta  <= 1'b0;
            locked_s   <= 1'b0;
            state      <= S_PLL_RST;
            cnt        <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            core_rst_n <= 1'b0;
            core_en    <= '0;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            lock_meta  <= pll_locked;
            locked_s   <= lock_meta;
            state      <= state_nx;
            cnt        <= cnt_nx;
            retry_cnt  <= retry_nx;
            pll_rst    <= (state_nx == S_PLL_RST) || (state_nx == S_FAIL);
            core_rst_n <= (state_nx == S_RUN);
            core_en    <= en_nx;
            ready      <= (state_nx == S_RUN) && (&en_nx);
            fail       <= (state_nx == S_FAIL);
        end
    end

    assign state_o = state;

`ifdef SHA_PLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_q <= 8'd0;
        end else if ((state == S_RUN) && !locked_s && (loss_q != 8'hff)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sha_pll_reset_seq.sv
// tb/tb_sha_pll_reset_seq.sv - randomized bench for sha_pll_reset_seq against a phase/age reference model
module tb_sha_pll_reset_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;
    localparam int NUM_CORES     = 4;
    localparam int STAGGER       = 2;
    localparam int CNT_W         = 16;

    localparam int P_PLL_RST = 0;
    localparam int P_WAIT    = 1;
    localparam int P_STABLE  = 2;
    localparam int P_RUN     = 3;
    localparam int P_FAIL    = 4;

    logic                 refclk = 1'b0;
    logic                 rst_n;
    logic                 pll_locked;
    logic                 retry_req;
    logic                 pll_rst;
    logic                 core_rst_n;
    logic [NUM_CORES-1:0] core_en;
    logic                 ready;
    logic                 fail;
    logic [2:0]           state_o;
    logic [7:0]           lock_loss_cnt;

    sha_pll_reset_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .NUM_CORES     (NUM_CORES),
        .STAGGER       (STAGGER),
        .CNT_W         (CNT_W)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .retry_req     (retry_req),
        .pll_rst       (pll_rst),
        .core_rst_n    (core_rst_n),
        .core_en       (core_en),
        .ready         (ready),
        .fail          (fail),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current phase, cycles spent in it, attempts used,
    // lock-loss events, and the last two pll_locked samples.
    int m_phase = P_PLL_RST;
    int m_age   = 0;
    int m_retry = 0;
    int m_loss  = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (phase %0d age %0d)", tag, obs, exp, m_phase, m_age);
        end
    endtask

    function automatic void enter(input int p);
        m_phase = p;
        m_age   = 0;
    endfunction

    function automatic void model_step(input bit lk, input bit rq, input bit rn);
        bit seen;
        if (!rn) begin
            m_phase = P_PLL_RST;
            m_age   = 0;
            m_retry = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        case (m_phase)
            P_PLL_RST: begin
                m_age++;
                if (m_age == RST_CYCLES) enter(P_WAIT);
            end
            P_WAIT: begin
                if (seen) enter(P_STABLE);
                else begin
                    m_age++;
                    if (m_age == LOCK_TIMEOUT) begin
                        if (m_retry == MAX_RETRY) enter(P_FAIL);
                        else begin
                            m_retry++;
                            enter(P_PLL_RST);
                        end
                    end
                end
            end
            P_STABLE: begin
                if (!seen) enter(P_WAIT);
                else begin
                    m_age++;
                    if (m_age == STABLE_CYCLES) begin
                        m_retry = 0;
                        enter(P_RUN);
                    end
                end
            end
            P_RUN: begin
                if (!seen) begin
                    if (m_loss < 255) m_loss++;
                    enter(P_PLL_RST);
                end else m_age++;
            end
            default: begin
                if (rq) begin
                    m_retry = 0;
                    enter(P_PLL_RST);
                end
            end
        endcase
    endfunction

    task automatic compare_outputs();
        logic [NUM_CORES-1:0] e_en;
        int e_loss;
        e_en = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (m_phase == P_RUN && m_age >= i * STAGGER) e_en[i] = 1'b1;
`ifdef SHA_PLL_LOCK_LOSS_CNT_EN
        e_loss = m_loss;
`else
        e_loss = 0;
`endif
        check_eq("state_o", 32'(state_o), 32'(m_phase));
        check_eq("pll_rst", 32'(pll_rst), 32'(m_phase == P_PLL_RST || m_phase == P_FAIL));
        check_eq("core_rst_n", 32'(core_rst_n), 32'(m_phase == P_RUN));
        check_eq("core_en", 32'(core_en), 32'(e_en));
        check_eq("ready", 32'(ready), 32'(m_phase == P_RUN && m_age >= (NUM_CORES - 1) * STAGGER));
        check_eq("fail", 32'(fail), 32'(m_phase == P_FAIL));
        check_eq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e_loss));
    endtask

    task automatic tick(input bit lk, input bit rq, input bit rn);
        @(negedge refclk);
        compare_outputs();
        pll_locked = lk;
        retry_req  = rq;
        rst_n      = rn;
        model_step(lk, rq, rn);
    endtask

    task automatic run_until(input int phase, input int age, input bit lk, input int budget);
        int n;
        n = 0;
        while (!(m_phase == phase && m_age == age) && n < budget) begin
            tick(lk, 1'b0, 1'b1);
            n++;
        end
        if (!(m_phase == phase && m_age == age))
            check_eq("reach_bound", 32'(m_phase), 32'(phase));
    endtask

    initial begin
        int hold;
        bit lk;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        retry_req  = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge refclk);

        // clean bring-up: lock 3 cycles after pll_rst falls
        run_until(P_WAIT, 0, 1'b0, 50);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        run_until(P_RUN, 3 * STAGGER + 2, 1'b1, 100);

        // one-cycle glitch at STABLE count 5
        tick(1'b1, 1'b0, 1'b0);
        run_until(P_STABLE, 5, 1'b1, 100);
        tick(1'b0, 1'b0, 1'b1);
        run_until(P_RUN, 8, 1'b1, 100);

        // no lock: retries exhaust into FAIL, retry_req leaves it
        tick(1'b0, 1'b0, 1'b0);
        run_until(P_FAIL, 0, 1'b0, 300);
        repeat (5) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b0, 1'b1);

        // lock loss while core_en = 0011
        run_until(P_RUN, STAGGER, 1'b1, 200);
        repeat (4) tick(1'b0, 1'b0, 1'b1);

        // retry_req ignored in RUN, then reset mid-run
        run_until(P_RUN, 10, 1'b1, 200);
        repeat (3) tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b1);

        // random lock behaviour, retry pulses and occasional resets
        lk = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 30);
                lk   = ($urandom_range(0, 3) != 0);
            end
            hold--;
            tick(lk, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) != 0));
        end

        // 260 lock-loss events for counter saturation
        tick(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 260; k++) begin
            run_until(P_RUN, 0, 1'b1, 100);
            repeat (3) tick(1'b0, 1'b0, 1'b1);
        end
        repeat (2) tick(1'b0, 1'b0, 1'b1);

        @(negedge refclk);
        compare_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
